freq_meter: RTL and testbench

//  Measures frequency (Hz) and peak amplitude of a signed sample stream, e.g. the output of the IIR/FIR filters.

---
 rtl/freq_meter_pkg.sv | 37 +++
 rtl/freq_meter_div.sv | 67 ++++++
 rtl/freq_meter.sv | 199 +++++++++++++++++++
 tb/tb_freq_meter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency / peak-amplitude meter.
// Contents: FSM state encoding, output saturation limits, divider widths,
// the gate snapshot payload and a saturating absolute-value helper.
package freq_meter_pkg;

  localparam int unsigned DIN_W  = 16;
  localparam int unsigned FREQ_W = 19;
  localparam int unsigned NUM_W  = 32;
  localparam int unsigned DEN_W  = 16;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned STEP_W = 5;

  localparam logic [FREQ_W-1:0] FREQ_MAX = 19'h7FFFF;
  localparam logic [DIN_W-1:0]  AMP_MAX  = 16'h7FFF;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_DIV = 2'd1,
    S_OUT = 2'd2
  } state_t;

  // Values captured at the end of a measurement gate
  typedef struct packed {
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] first;
    logic [IDX_W-1:0] last;
    logic [DIN_W-1:0] pk;
  } snap_t;

  // |x| with the one unrepresentable magnitude (-32768) clamped to 32767
  function automatic logic [DIN_W-1:0] abs_sat(input logic signed [DIN_W-1:0] x);
    if (x == 16'sh8000) return AMP_MAX;
    else if (x[DIN_W-1]) return DIN_W'(-x);
    else return DIN_W'(x);
  endfunction

endpackage

// File: rtl/freq_meter_div.sv
// Sequential restoring divider, 32-bit numerator by 16-bit denominator,
// one quotient bit per clock (32 iteration clocks after the start clock).
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts a divide)
//   start      load num/den and begin; ignored while busy
//   num, den   dividend / divisor
//   busy       high while iterating
//   done       one-clock pulse when quo is valid
//   quo        quotient; holds until the next start
module freq_meter_div
  import freq_meter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  logic [DEN_W-1:0]  rem;
  logic [DEN_W-1:0]  dsr;
  logic [STEP_W-1:0] step;
  logic [DEN_W:0]    trial_c;
  logic [DEN_W-1:0]  diff_c;
  logic              fit_c;

  // Trial subtraction of the divisor from the shifted partial remainder;
  // diff wraps harmlessly because it is only used when the divisor fits
  always_comb begin
    trial_c = {rem, quo[NUM_W-1]};
    fit_c   = (trial_c >= {1'b0, dsr});
    diff_c  = trial_c[DEN_W-1:0] - dsr;
  end

  // quo doubles as the dividend shift register while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      quo  <= '0;
      rem  <= '0;
      dsr  <= '0;
      step <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        rem  <= fit_c ? diff_c : trial_c[DEN_W-1:0];
        quo  <= {quo[NUM_W-2:0], fit_c};
        step <= step + STEP_W'(1);
        if (step == STEP_W'(NUM_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        rem  <= '0;
        quo  <= num;
        dsr  <= den;
        step <= '0;
        busy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Frequency (Hz) and peak |din| meter for a signed sample stream.
// Counts hysteresis-qualified rising zero crossings over a gate of
// GATE_SAMPLES strobes and reports freq = (crossings-1)*FS_HZ / span.
// Optional macro FREQ_METER_ROUND_EN: round the quotient to nearest
// instead of truncating.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   f_s     sample strobe, asynchronous to clk (period >= 40 clk)
//   din     signed sample, held constant between strobes
//   freq    measured frequency in Hz, saturating at 19'h7FFFF
//   amp     peak |din| over the last gate
//   no_sig  last gate held fewer than 2 rising crossings
//   valid   one-clock pulse when freq/amp/no_sig update
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned FS_HZ        = 40000,
  parameter int unsigned GATE_SAMPLES = 4000,
  parameter int unsigned HYST         = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    f_s,
  input  logic signed [DIN_W-1:0] din,
  output logic [FREQ_W-1:0]       freq,
  output logic [DIN_W-1:0]        amp,
  output logic                    no_sig,
  output logic                    valid
);

  localparam int unsigned          HW       = DIN_W + 1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(GATE_SAMPLES - 1);
  localparam logic signed [DIN_W:0] HYST_POS = HW'(HYST);
  localparam logic signed [DIN_W:0] HYST_NEG = -HYST_POS;

  logic [2:0]              f_sync;
  logic                    strobe_c;
  logic                    stb_q;
  logic signed [DIN_W-1:0] din_q;
  logic                    armed;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        cnt, first, last;
  logic [DIN_W-1:0]        pk;
  snap_t                   snap;
  logic                    gate_done;

  logic signed [DIN_W:0]   din_x_c;
  logic [DIN_W-1:0]        abs_c;
  logic                    neg_c, cross_c, gate_end_c;
  logic [IDX_W-1:0]        cnt_n, first_n, last_n;
  logic [DIN_W-1:0]        pk_n;

  state_t                  state, state_n;
  logic                    div_start_c, out_load_c;
  logic [NUM_W-1:0]        num_c;
  logic [DEN_W-1:0]        den_c;
  logic                    div_busy, div_done;
  logic [NUM_W-1:0]        div_quo;

  // Falling edge of the synchronised f_s
  assign strobe_c = f_sync[2] & ~f_sync[1];

  // Per-sample acquisition results, including the current sample
  always_comb begin
    din_x_c    = {din_q[DIN_W-1], din_q};
    abs_c      = abs_sat(din_q);
    neg_c      = (din_x_c < HYST_NEG);
    cross_c    = armed && (din_x_c >= HYST_POS);
    gate_end_c = stb_q && (idx == IDX_LAST);
    cnt_n      = cnt;
    first_n    = first;
    last_n     = last;
    pk_n       = pk;
    if (cross_c) begin
      cnt_n  = cnt + IDX_W'(1);
      last_n = idx;
      if (cnt == '0) first_n = idx;
    end
    if (abs_c > pk) pk_n = abs_c;
  end

  // Synchroniser, sample capture, hysteresis and gate accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      f_sync    <= '0;
      stb_q     <= 1'b0;
      din_q     <= '0;
      armed     <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      first     <= '0;
      last      <= '0;
      pk        <= '0;
      snap      <= '0;
      gate_done <= 1'b0;
    end else begin
      f_sync    <= {f_sync[1:0], f_s};
      stb_q     <= strobe_c;
      if (strobe_c) din_q <= din;
      gate_done <= gate_end_c;
      if (stb_q) begin
        if (neg_c) armed <= 1'b1;
        else if (cross_c) armed <= 1'b0;
        first <= first_n;
        last  <= last_n;
        if (gate_end_c) begin
          snap <= '{cnt: cnt_n, first: first_n, last: last_n, pk: pk_n};
          cnt  <= '0;
          pk   <= '0;
          idx  <= '0;
        end else begin
          cnt <= cnt_n;
          pk  <= pk_n;
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Divider operands from the gate snapshot
  always_comb begin
    num_c = NUM_W'(snap.cnt - IDX_W'(1)) * NUM_W'(FS_HZ);
    den_c = DEN_W'(snap.last - snap.first);
`ifdef FREQ_METER_ROUND_EN
    num_c = num_c + NUM_W'(den_c >> 1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_n;
  end

  // Gate sequencing: skip the divide when there is nothing to measure
  always_comb begin
    state_n     = state;
    div_start_c = 1'b0;
    out_load_c  = 1'b0;
    unique case (state)
      S_RUN: begin
        if (gate_done) begin
          if (snap.cnt < IDX_W'(2)) begin
            state_n = S_OUT;
          end else begin
            div_start_c = 1'b1;
            state_n     = S_DIV;
          end
        end
      end
      S_DIV: if (div_done) state_n = S_OUT;
      S_OUT: begin
        out_load_c = 1'b1;
        state_n    = S_RUN;
      end
      default: state_n = S_RUN;
    endcase
  end

  freq_meter_div u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start_c),
    .num   (num_c),
    .den   (den_c),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // Result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      freq   <= '0;
      amp    <= '0;
      no_sig <= 1'b1;
      valid  <= 1'b0;
    end else begin
      valid <= out_load_c;
      if (out_load_c) begin
        amp <= snap.pk;
        if (snap.cnt < IDX_W'(2)) begin
          freq   <= '0;
          no_sig <= 1'b1;
        end else begin
          freq   <= (div_quo > NUM_W'(FREQ_MAX)) ? FREQ_MAX : div_quo[FREQ_W-1:0];
          no_sig <= 1'b0;
        end
      end
    end
  end

  // A gate can only finish while idle if f_s respects its minimum period
  a_gate_in_run: assert property (@(posedge clk) disable iff (rst)
    gate_done |-> (state == S_RUN));
  a_start_idle: assert property (@(posedge clk) disable iff (rst)
    div_start_c |-> !div_busy);

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with a short gate (50 samples) so a
// full run stays small. Expected results come from a per-gate model that
// applies the crossing/hysteresis rules to the sample array directly.
module tb_freq_meter;

  localparam int FS     = 40000;
  localparam int GATE   = 50;
  localparam int HYST   = 512;
  localparam int FS_PER = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              f_s = 1'b0;
  logic signed [15:0] din = '0;
  logic [18:0]       freq;
  logic [15:0]       amp;
  logic              no_sig;
  logic              valid;

  freq_meter #(.FS_HZ(FS), .GATE_SAMPLES(GATE), .HYST(HYST)) dut (
    .clk    (clk),
    .rst    (rst),
    .f_s    (f_s),
    .din    (din),
    .freq   (freq),
    .amp    (amp),
    .no_sig (no_sig),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int freq;
    int amp;
    bit no_sig;
  } res_t;

  typedef struct {
    int period;
    int hi;
    int lo;
    int exp_freq;
    int exp_amp;
    bit exp_no_sig;
  } vec_t;

  res_t got_q[$];
  int   gbuf[GATE];
  bit   m_armed;
  int   n_checks;
  int   n_fail;
  int   valid_cycles;
  int   exp_valids;

  // Collect every result pulse
  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back('{int'(freq), int'(amp), no_sig});
      valid_cycles++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_near(input string name, input int got, input int exp, input int tol);
    n_checks++;
    if (got < exp - tol || got > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, got, exp, tol);
    end
  endtask

  // One f_s period: din changes while f_s is high, f_s falls mid-period
  task automatic send_sample(input int v, input int post);
    @(negedge clk);
    din = 16'(v);
    f_s = 1'b1;
    repeat (FS_PER / 2 - 1) @(negedge clk);
    f_s = 1'b0;
    repeat (post) @(negedge clk);
  endtask

  function automatic void fill_square(input int p, input int hi, input int lo, input int base);
    for (int i = 0; i < GATE; i++)
      gbuf[i] = (((base + i) % p) < (p / 2)) ? hi : lo;
  endfunction

  function automatic void fill_sine(input real f, input real a, input int base,
                                    input int noise, input int from);
    real v;
    int  s;
    for (int i = from; i < GATE; i++) begin
      v = a * $sin(2.0 * 3.14159265358979 * f * real'(base + i) / real'(FS));
      s = $rtoi(v);
      if (noise > 0) s = s + int'($urandom_range(2 * noise)) - noise;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      gbuf[i] = s;
    end
  endfunction

  // Reference: reciprocal count over the gate's qualified rising crossings
  function automatic void model_gate(output res_t e);
    int     n, first, last, pk, a;
    longint num, den, q;
    n = 0; first = 0; last = 0; pk = 0;
    for (int i = 0; i < GATE; i++) begin
      a = (gbuf[i] == -32768) ? 32767 : ((gbuf[i] < 0) ? -gbuf[i] : gbuf[i]);
      if (a > pk) pk = a;
      if (gbuf[i] < -HYST) m_armed = 1'b1;
      else if (m_armed && gbuf[i] >= HYST) begin
        m_armed = 1'b0;
        if (n == 0) first = i;
        last = i;
        n++;
      end
    end
    e.amp = pk;
    if (n < 2) begin
      e.freq   = 0;
      e.no_sig = 1'b1;
    end else begin
      num = longint'(n - 1) * FS;
      den = longint'(last - first);
`ifdef FREQ_METER_ROUND_EN
      num = num + den / 2;
`endif
      q = num / den;
      if (q > 'h7FFFF) q = 'h7FFFF;
      e.freq   = int'(q);
      e.no_sig = 1'b0;
    end
  endfunction

  task automatic wait_result(input string tag, output res_t g, output bit ok);
    ok = 1'b0;
    g  = '{0, 0, 1'b0};
    for (int t = 0; t < 100 && got_q.size() == 0; t++) @(negedge clk);
    if (got_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout: got no valid pulse, expected one", tag);
    end else begin
      g  = got_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Send gbuf as one gate and compare the DUT report with the model
  task automatic run_gate(input string tag, output res_t g, output bit ok);
    res_t e;
    for (int i = 0; i < GATE; i++) send_sample(gbuf[i], 20);
    model_gate(e);
    exp_valids++;
    wait_result(tag, g, ok);
    if (ok) begin
      check({tag, ".freq"},   g.freq,   e.freq);
      check({tag, ".amp"},    g.amp,    e.amp);
      check({tag, ".no_sig"}, g.no_sig, e.no_sig);
    end
  endtask

  initial begin
    vec_t  tbl[9];
    res_t  g;
    bit    ok;
    string tag;

    tbl[0] = '{10, 16000, -16000,  4000, 16000, 1'b0};
    tbl[1] = '{ 8, 20000, -20000,  5000, 20000, 1'b0};
    tbl[2] = '{25,  1000,  -1000,  1600,  1000, 1'b0};
    tbl[3] = '{ 2, 32767, -32768, 20000, 32767, 1'b0};
    tbl[4] = '{40, 30000, -30000,     0, 30000, 1'b1};
    tbl[5] = '{10,   511,   -511,     0,   511, 1'b1};
    tbl[6] = '{10,   512,   -513,  4000,   513, 1'b0};
    tbl[7] = '{10,   513,   -512,     0,   513, 1'b1};
    tbl[8] = '{10,     0,      0,     0,     0, 1'b1};

    n_checks = 0; n_fail = 0; valid_cycles = 0; exp_valids = 0;
    m_armed = 1'b0;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.freq",   int'(freq),   0);
    check("reset.amp",    int'(amp),    0);
    check("reset.no_sig", int'(no_sig), 1);
    check("reset.valid",  int'(valid),  0);

    // Square waves: second gate of each entry has fixed, known results
    for (int k = 0; k < 9; k++) begin
      tag = $sformatf("sq%0d", k);
      fill_square(tbl[k].period, tbl[k].hi, tbl[k].lo, 0);
      run_gate({tag, "a"}, g, ok);
      fill_square(tbl[k].period, tbl[k].hi, tbl[k].lo, GATE);
      run_gate({tag, "b"}, g, ok);
      if (ok) begin
        check({tag, ".tbl_freq"},   g.freq,   tbl[k].exp_freq);
        check({tag, ".tbl_amp"},    g.amp,    tbl[k].exp_amp);
        check({tag, ".tbl_no_sig"}, g.no_sig, tbl[k].exp_no_sig);
      end
    end

    // Lone full-scale negative sample: clamped peak, then back to zero
    for (int i = 0; i < GATE; i++) gbuf[i] = 0;
    gbuf[17] = -32768;
    run_gate("spike", g, ok);
    if (ok) check("spike.amp32767", g.amp, 32767);
    gbuf[17] = 0;
    run_gate("spike_next", g, ok);
    if (ok) check("spike_next.amp0", g.amp, 0);

    // Low-frequency sine: too few crossings in a short gate
    fill_sine(400.0, 16000.0, 0, 0, 0);
    run_gate("sine400", g, ok);

    // Frequency switch mid-gate, then settled gate
    fill_sine(2000.0, 16000.0, 0, 0, 0);
    fill_sine(4000.0, 16000.0, 0, 0, 25);
    run_gate("switch", g, ok);
    fill_sine(4000.0, 16000.0, GATE, 0, 0);
    run_gate("sine4000", g, ok);
    if (ok) check_near("sine4000.near", g.freq, 4000, 1);

    // Near-Nyquist full-scale sine
    fill_sine(19000.0, 32767.0, 0, 0, 0);
    run_gate("sine19k", g, ok);

    // Randomised sines with noise
    for (int r = 0; r < 8; r++) begin
      fill_sine(real'($urandom_range(19500, 1700)), real'($urandom_range(32000, 600)),
                int'($urandom_range(1000)), int'($urandom_range(300)), 0);
      run_gate($sformatf("rnd%0d", r), g, ok);
    end

    // Reset while the divider is running: no report, outputs cleared
    fill_square(10, 16000, -16000, 0);
    for (int i = 0; i < GATE - 1; i++) send_sample(gbuf[i], 20);
    send_sample(gbuf[GATE-1], 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.freq",   int'(freq),   0);
    check("abort.amp",    int'(amp),    0);
    check("abort.no_sig", int'(no_sig), 1);
    check("abort.valid",  int'(valid),  0);
    repeat (60) @(negedge clk);
    check("abort.no_pulse", got_q.size(), 0);
    got_q.delete();
    m_armed = 1'b0;
    fill_square(10, 16000, -16000, 0);
    run_gate("post_abort_a", g, ok);
    fill_square(10, 16000, -16000, GATE);
    run_gate("post_abort_b", g, ok);
    if (ok) check("post_abort.freq4000", g.freq, 4000);

    repeat (60) @(negedge clk);
    check("valid_cycles", valid_cycles, exp_valids);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
